// File: rtl/forward_ctrl_unit_pkg.sv
// Shared types for the EX-stage forwarding / hazard control slice.
//   forwardCtrl_e : operand-mux select for the EX rs1/rs2 inputs
//   stage_tag_t   : destination tag carried by each shadow pipeline stage
//   ctrl_mode_e   : which of the per-cycle pipeline actions won this cycle
package forward_ctrl_unit_pkg;

  // Register-index width of the tags; the top's REG_AW defaults to this.
  localparam int unsigned TAG_RD_W = 5;

  typedef enum logic [1:0] {
    FORWARD_NONE     = 2'd0,
    FORWARD_FROM_MEM = 2'd1,
    FORWARD_FROM_WB  = 2'd2
  } forwardCtrl_e;

  typedef struct packed {
    logic                valid;
    logic [TAG_RD_W-1:0] rd;
    logic                reg_write;
    logic                is_load;
  } stage_tag_t;

  // Empty stage. Invalid tags are always kept all-zero so a stale rd can
  // never leak into a compare.
  localparam stage_tag_t TAG_INVALID = '0;

  typedef enum logic [1:0] {
    MODE_ADVANCE  = 2'd0,
    MODE_FREEZE   = 2'd1,
    MODE_FLUSH    = 2'd2,
    MODE_LOAD_USE = 2'd3
  } ctrl_mode_e;

endpackage

// File: rtl/forward_ctrl_unit_fwd_match.sv
// fwd_match: combinational compare of one ID source index against the
// EX and MEM shadow tags, producing the forward select that the operand
// will need once the ID instruction has moved into EX.
//   rs            : ID source register index
//   ex_tag        : tag of the instruction currently in EX
//   mem_valid/rd/reg_write : fields of the tag currently in MEM
//   sel           : resulting forward select
module fwd_match
  import forward_ctrl_unit_pkg::*;
(
  input  logic [TAG_RD_W-1:0] rs,
  input  stage_tag_t          ex_tag,
  input  logic                mem_valid,
  input  logic [TAG_RD_W-1:0] mem_rd,
  input  logic                mem_reg_write,
  output forwardCtrl_e        sel
);

  logic rs_nonzero;
  logic ex_hit;
  logic mem_hit;

  // x0 is hard-wired, so a zero source never takes a forwarded value.
  // A load in EX cannot forward from MEM; that case is a load-use stall.
  always_comb begin
    rs_nonzero = (rs != '0);
    ex_hit     = rs_nonzero & ex_tag.valid & ex_tag.reg_write
                 & ~ex_tag.is_load & (ex_tag.rd == rs);
    mem_hit    = rs_nonzero & mem_valid & mem_reg_write & (mem_rd == rs);
  end

  // The younger producer (EX) wins over the older one (MEM).
  always_comb begin
    sel = FORWARD_NONE;
    if (ex_hit) begin
      sel = FORWARD_FROM_MEM;
    end else if (mem_hit) begin
      sel = FORWARD_FROM_WB;
    end
  end

endmodule

// File: rtl/forward_ctrl_unit.sv
// forward_ctrl_unit: forwarding-select and stall/flush control for the
// 5-stage RV32 core. Keeps a shadow copy of the destination tags in EX,
// MEM and WB and from them derives the registered EX operand selects and
// the same-cycle stall, flush and bubble controls.
//   clk, rst_n              : clock, asynchronous active-low reset
//   id_*                    : decoded fields of the instruction in ID
//   ex_branch_taken         : EX redirects the PC this cycle
//   dmem_busy               : data memory not ready, whole pipe freezes
//   fwd_sel_rs1/rs2         : registered forward selects for EX operands
//   stall_if/stall_id       : hold PC / hold IF-ID register
//   flush_id                : clear IF-ID register
//   bubble_ex               : load a NOP into ID-EX register
//   stall_cycles            : saturating count of cycles with stall_id set
module forward_ctrl_unit
  import forward_ctrl_unit_pkg::*;
#(
  parameter int unsigned REG_AW = TAG_RD_W,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_reg_write,
  input  logic              id_is_load,
  input  logic              ex_branch_taken,
  input  logic              dmem_busy,
  output forwardCtrl_e      fwd_sel_rs1,
  output forwardCtrl_e      fwd_sel_rs2,
  output logic              stall_if,
  output logic              stall_id,
  output logic              flush_id,
  output logic              bubble_ex,
  output logic [CNT_W-1:0]  stall_cycles
);

  stage_tag_t       ex_tag_q, ex_tag_d;
  stage_tag_t       mem_tag_q, mem_tag_d;
  stage_tag_t       wb_tag_q, wb_tag_d;
  stage_tag_t       id_tag;
  forwardCtrl_e     fwd_sel_rs1_q, fwd_sel_rs1_d;
  forwardCtrl_e     fwd_sel_rs2_q, fwd_sel_rs2_d;
  forwardCtrl_e     id_sel_rs1, id_sel_rs2;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic             ex_load_pending;
  logic             load_use;
  ctrl_mode_e       mode;

  // Tag the ID instruction would carry into EX; a non-instruction becomes
  // an all-zero invalid tag.
  always_comb begin
    id_tag = TAG_INVALID;
    if (id_valid) begin
      id_tag.valid     = 1'b1;
      id_tag.rd        = id_rd;
      id_tag.reg_write = id_reg_write;
      id_tag.is_load   = id_is_load;
    end
  end

  fwd_match u_fwd_rs1 (
    .rs            (id_rs1),
    .ex_tag        (ex_tag_q),
    .mem_valid     (mem_tag_q.valid),
    .mem_rd        (mem_tag_q.rd),
    .mem_reg_write (mem_tag_q.reg_write),
    .sel           (id_sel_rs1)
  );

  fwd_match u_fwd_rs2 (
    .rs            (id_rs2),
    .ex_tag        (ex_tag_q),
    .mem_valid     (mem_tag_q.valid),
    .mem_rd        (mem_tag_q.rd),
    .mem_reg_write (mem_tag_q.reg_write),
    .sel           (id_sel_rs2)
  );

  // A load in EX whose data only exists after MEM: the consumer in ID must
  // wait one cycle and then picks the value up from the WB path.
  always_comb begin
    ex_load_pending = ex_tag_q.valid & ex_tag_q.is_load & ex_tag_q.reg_write
                      & (ex_tag_q.rd != '0);
    load_use        = id_valid & ex_load_pending
                      & ((ex_tag_q.rd == id_rs1) | (ex_tag_q.rd == id_rs2));
  end

  // Priority: memory freeze beats branch flush beats load-use stall.
  always_comb begin
    mode = MODE_ADVANCE;
    if (dmem_busy) begin
      mode = MODE_FREEZE;
    end else if (ex_branch_taken) begin
      mode = MODE_FLUSH;
    end else if (load_use) begin
      mode = MODE_LOAD_USE;
    end
  end

  // Pipeline controls and shadow-pipeline next state. Flush and load-use
  // both insert a bubble into EX while older tags keep draining.
  always_comb begin
    stall_if      = 1'b0;
    stall_id      = 1'b0;
    flush_id      = 1'b0;
    bubble_ex     = 1'b0;
    ex_tag_d      = ex_tag_q;
    mem_tag_d     = mem_tag_q;
    wb_tag_d      = wb_tag_q;
    fwd_sel_rs1_d = fwd_sel_rs1_q;
    fwd_sel_rs2_d = fwd_sel_rs2_q;
    unique case (mode)
      MODE_FREEZE: begin
        stall_if = 1'b1;
        stall_id = 1'b1;
      end
      MODE_FLUSH: begin
        flush_id      = 1'b1;
        bubble_ex     = 1'b1;
        ex_tag_d      = TAG_INVALID;
        mem_tag_d     = ex_tag_q;
        wb_tag_d      = mem_tag_q;
        fwd_sel_rs1_d = FORWARD_NONE;
        fwd_sel_rs2_d = FORWARD_NONE;
      end
      MODE_LOAD_USE: begin
        stall_if      = 1'b1;
        stall_id      = 1'b1;
        bubble_ex     = 1'b1;
        ex_tag_d      = TAG_INVALID;
        mem_tag_d     = ex_tag_q;
        wb_tag_d      = mem_tag_q;
        fwd_sel_rs1_d = FORWARD_NONE;
        fwd_sel_rs2_d = FORWARD_NONE;
      end
      default: begin
        ex_tag_d      = id_tag;
        mem_tag_d     = ex_tag_q;
        wb_tag_d      = mem_tag_q;
        fwd_sel_rs1_d = id_sel_rs1;
        fwd_sel_rs2_d = id_sel_rs2;
      end
    endcase
  end

  // Stall-cycle counter sticks at all-ones instead of wrapping.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (stall_id && (stall_cycles_q != {CNT_W{1'b1}})) begin
      stall_cycles_d = stall_cycles_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_tag_q       <= TAG_INVALID;
      mem_tag_q      <= TAG_INVALID;
      wb_tag_q       <= TAG_INVALID;
      fwd_sel_rs1_q  <= FORWARD_NONE;
      fwd_sel_rs2_q  <= FORWARD_NONE;
      stall_cycles_q <= '0;
    end else begin
      ex_tag_q       <= ex_tag_d;
      mem_tag_q      <= mem_tag_d;
      wb_tag_q       <= wb_tag_d;
      fwd_sel_rs1_q  <= fwd_sel_rs1_d;
      fwd_sel_rs2_q  <= fwd_sel_rs2_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign fwd_sel_rs1  = fwd_sel_rs1_q;
  assign fwd_sel_rs2  = fwd_sel_rs2_q;
  assign stall_cycles = stall_cycles_q;

  // The WB tag is not needed to make decisions; it cross-checks that a
  // WB forward always points at a real register-writing producer.
  a_wb_fwd_source : assert property (@(posedge clk) disable iff (!rst_n)
    ((fwd_sel_rs1_q == FORWARD_FROM_WB) || (fwd_sel_rs2_q == FORWARD_FROM_WB))
    |-> (wb_tag_q.valid && wb_tag_q.reg_write && (wb_tag_q.rd != '0)));

  a_wb_invalid_clean : assert property (@(posedge clk) disable iff (!rst_n)
    !wb_tag_q.valid |-> (wb_tag_q == TAG_INVALID));

endmodule
